sd_dat_block_rx: RTL and testbench
==================================

Name: sd_dat_block_rx

Overview:
Hardware receive engine for the 4-bit SD card DAT bus. It lets software stop bit-banging DAT[3:0] through the bidirectional PIO when reading data blocks.
- Armed by a start pulse, then waits for the card's start bit.
- Shifts in one data block of BLOCK_BYTES bytes and emits it as a byte stream.
- Checks the per-line CRC16 and the end bit, then reports status.
It sits beside the sd_dat PIO, which keeps ownership of bus direction and drives DAT only for writes. This block only samples dat_in.

Parameters:
BLOCK_BYTES, 512, payload bytes per block (even, ≥2).
TIMEOUT_TICKS, 65535, sample_en ticks allowed in WAIT_START before timeout.

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; arms the receiver (ignored unless IDLE)
abort  input  1  synchronous; returns to IDLE, no done pulse
sample_en  input  1  one-cycle strobe per SD clock rising edge (sample point)
dat_in  input  4  DAT[3:0] as seen at the pad (already synchronised)
rx_data  output  8  received byte
rx_valid  output  1  one-cycle pulse, rx_data valid; no backpressure
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse at block completion or timeout
crc_err  output  1  sticky; CRC mismatch on any line
end_err  output  1  sticky; end bit not 4'b1111
timeout_err  output  1  sticky; no start bit within TIMEOUT_TICKS

Behaviour:
- Reset values: all outputs 0, state IDLE, all counters and CRC registers 0.
- State advances only on clk edges where sample_en=1, except start and abort, which act on any clk.
- IDLE:
  - start=1 → WAIT_START.
  - Clears crc_err, end_err, timeout_err, the tick counter and all four CRC registers.
- WAIT_START:
  - Sample with dat_in==4'b0000 → DATA, nibble counter=0.
  - Any other value (including partial zeros) is ignored, and the tick counter increments.
  - When the counter reaches TIMEOUT_TICKS: set timeout_err, pulse done, → IDLE.
- DATA:
  - Each sample takes one nibble; the high nibble arrives first.
  - Even nibble index: stored as hi.
  - Odd index: rx_data<={hi,dat_in} and rx_valid=1 on the next clk, i.e. 1 clk after the sample_en carrying the low nibble.
  - Each dat_in[i] is fed to CRC engine i.
  - After nibble 2*BLOCK_BYTES-1 → CRC, bit counter=0.
- CRC:
  - 16 samples, MSB first.
  - Each dat_in[i] is compared with bit 15-k of CRC engine i's frozen value; any mismatch sets crc_err.
  - After the 16th sample → END.
- END:
  - One sample; dat_in!=4'b1111 sets end_err.
  - done pulses on the next clk, state → IDLE.
  - crc_err and end_err are valid when done=1 and hold until the next start.
- CRC16: CCITT x^16+x^12+x^5+1, init 0x0000, one instance per line, covering data bits only (not start, CRC or end bits).
- Simultaneous events:
  - abort has priority over everything, including a sample_en in the same clk; no rx_valid or done is generated.
  - start while busy is ignored.
  - start and sample_en in the same clk in IDLE → WAIT_START only; that sample is not examined.
- Reset mid-block: asynchronous return to IDLE, outputs 0, no done.
- Minimum sample_en spacing is 2 clks; back-to-back strobes need not be supported.

Decomposition:
- Package sd_pkg:
  - state enum (IDLE, WAIT_START, DATA, CRC, END)
  - CRC16_POLY=16'h1021
  - CRC16_INIT=16'h0000
  - SD_START_NIBBLE=4'h0
  - SD_END_NIBBLE=4'hF
- Sub-module sd_crc16_serial: 1-bit serial CRC16 with clr, en, din and crc[15:0]. Instantiated 4×; the same module is reused later by the TX engine.

Test Plan:
- BLOCK_BYTES=4, start, 3 idle samples of 4'hF, start nibble, data bytes 0x12 0x34 0xAB 0xCD, correct per-line CRCs, end 4'hF → rx_valid ×4 with 0x12,0x34,0xAB,0xCD; done=1 once; crc_err=end_err=timeout_err=0.
- All-zero 4-byte payload with CRC bits all 0 → pass; repeat with one CRC bit on DAT2 flipped → crc_err=1, rx bytes still delivered, done=1.
- Correct block but end nibble 4'b1110 → end_err=1, crc_err=0, done=1.
- TIMEOUT_TICKS=8, start, 8 samples of 4'hF → timeout_err=1 and done=1 one clk after the 8th sample; busy=0 afterwards, rx_valid never asserted.
- Abort asserted after 2 bytes, coincident with a sample_en → no further rx_valid, no done, busy=0 next clk; a new start plus full block then succeeds.
- reset_n low mid-DATA → all outputs 0 immediately; start issued during busy is ignored (byte count unchanged).

Source files
------------

// File: rtl/sd_pkg.sv
// Shared constants and types for the SD DAT-line engines (4-bit bus, CRC16 per line).
package sd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        DATA,
        CRC,
        END
    } sd_state_e;

    localparam logic [15:0] CRC16_POLY      = 16'h1021;
    localparam logic [15:0] CRC16_INIT      = 16'h0000;
    localparam logic [3:0]  SD_START_NIBBLE = 4'h0;
    localparam logic [3:0]  SD_END_NIBBLE   = 4'hF;

endpackage

// File: rtl/sd_crc16_serial.sv
// Bit-serial CRC16-CCITT (x^16+x^12+x^5+1), one bit per enabled clock.
module sd_crc16_serial
    import sd_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);

    logic [15:0] crc_q;
    logic        fb;

    assign fb  = din ^ crc_q[15];
    assign crc = crc_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_q <= 16'h0000;
        end else if (clr) begin
            crc_q <= CRC16_INIT;
        end else if (en) begin
            crc_q <= {crc_q[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
        end
    end

endmodule

// File: rtl/sd_dat_block_rx.sv
// SD 4-bit DAT receive engine: start bit, BLOCK_BYTES payload, per-line CRC16, end bit.
module sd_dat_block_rx
    import sd_pkg::*;
#(
    parameter int BLOCK_BYTES   = 512,
    parameter int TIMEOUT_TICKS = 65535
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       abort,
    input  logic       sample_en,
    input  logic [3:0] dat_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       done,
    output logic       crc_err,
    output logic       end_err,
    output logic       timeout_err
);

    localparam int NW = $clog2(2 * BLOCK_BYTES);
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [NW-1:0] NIB_LAST  = NW'(2 * BLOCK_BYTES - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TIMEOUT_TICKS - 1);

    sd_state_e       state_q;
    logic [NW-1:0]   nib_q;
    logic [3:0]      bit_q;
    logic [TW-1:0]   tick_q;
    logic [3:0]      hi_q;
    logic [7:0]      rx_data_q;
    logic            rx_valid_q;
    logic            done_q;
    logic            crc_err_q;
    logic            end_err_q;
    logic            timeout_err_q;

    logic [3:0][15:0] crc_w;
    logic [3:0]       crc_exp;
    logic             crc_clr;
    logic             crc_en;

    // CRC state is frozen outside DATA so the CRC phase can compare against it.
    assign crc_clr = (state_q == IDLE) && start && !abort;
    assign crc_en  = (state_q == DATA) && sample_en && !abort;

    for (genvar i = 0; i < 4; i++) begin : g_crc
        sd_crc16_serial u_crc (
            .clk     (clk),
            .reset_n (reset_n),
            .clr     (crc_clr),
            .en      (crc_en),
            .din     (dat_in[i]),
            .crc     (crc_w[i])
        );
    end

    always_comb begin
        crc_exp = 4'h0;
        for (int i = 0; i < 4; i++) begin
            crc_exp[i] = crc_w[i][4'd15 - bit_q];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            nib_q         <= '0;
            bit_q         <= 4'h0;
            tick_q        <= '0;
            hi_q          <= 4'h0;
            rx_data_q     <= 8'h00;
            rx_valid_q    <= 1'b0;
            done_q        <= 1'b0;
            crc_err_q     <= 1'b0;
            end_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            done_q     <= 1'b0;
            if (abort) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            state_q       <= WAIT_START;
                            tick_q        <= '0;
                            crc_err_q     <= 1'b0;
                            end_err_q     <= 1'b0;
                            timeout_err_q <= 1'b0;
                        end
                    end
                    WAIT_START: begin
                        if (sample_en) begin
                            if (dat_in == SD_START_NIBBLE) begin
                                state_q <= DATA;
                                nib_q   <= '0;
                            end else begin
                                tick_q <= tick_q + TW'(1);
                                if (tick_q == TICK_LAST) begin
                                    timeout_err_q <= 1'b1;
                                    done_q        <= 1'b1;
                                    state_q       <= IDLE;
                                end
                            end
                        end
                    end
                    DATA: begin
                        if (sample_en) begin
                            nib_q <= nib_q + NW'(1);
                            if (!nib_q[0]) begin
                                hi_q <= dat_in;
                            end else begin
                                rx_data_q  <= {hi_q, dat_in};
                                rx_valid_q <= 1'b1;
                            end
                            if (nib_q == NIB_LAST) begin
                                state_q <= CRC;
                                bit_q   <= 4'h0;
                            end
                        end
                    end
                    CRC: begin
                        if (sample_en) begin
                            if (dat_in != crc_exp) crc_err_q <= 1'b1;
                            bit_q <= bit_q + 4'h1;
                            if (bit_q == 4'hF) state_q <= END;
                        end
                    end
                    END: begin
                        if (sample_en) begin
                            if (dat_in != SD_END_NIBBLE) end_err_q <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign crc_err     = crc_err_q;
    assign end_err     = end_err_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_sd_dat_block_rx.sv
// Directed bench for sd_dat_block_rx with a byte scoreboard fed at drive time.
module tb_sd_dat_block_rx;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       sample_en = 1'b0;
    logic [3:0] dat_in = 4'hF;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       done;
    logic       crc_err;
    logic       end_err;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int rx_cnt = 0;
    logic [7:0] exp_q[$];

    sd_dat_block_rx #(.BLOCK_BYTES(4), .TIMEOUT_TICKS(8)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .abort       (abort),
        .sample_en   (sample_en),
        .dat_in      (dat_in),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .busy        (busy),
        .done        (done),
        .crc_err     (crc_err),
        .end_err     (end_err),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every rx_valid pulse must match the oldest pushed byte.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (rx_valid) begin
            rx_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL rx_unexpected: observed byte %0h expected no rx_valid", rx_data);
                end
            end else begin
                chk("rx_data", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic b);
        logic fb;
        fb = b ^ c[15];
        crc_upd = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    task automatic sample(input logic [3:0] n);
        @(negedge clk);
        sample_en = 1'b1;
        dat_in    = n;
        @(negedge clk);
        sample_en = 1'b0;
        dat_in    = 4'hF;
    endtask

    task automatic start_pulse();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Start nibble, 4 bytes, per-line CRCs (optionally corrupting DAT2's first CRC bit), end nibble.
    task automatic send_block(input logic [31:0] blk, input bit flip2, input logic [3:0] endn,
                              input bit mid_start);
        logic [15:0] crc [4];
        logic [7:0]  b;
        logic [3:0]  nb;
        for (int i = 0; i < 4; i++) crc[i] = 16'h0000;
        sample(4'h0);
        for (int j = 0; j < 4; j++) begin
            b = blk[31 - 8*j -: 8];
            for (int i = 0; i < 4; i++) crc[i] = crc_upd(crc[i], b[4+i]);
            for (int i = 0; i < 4; i++) crc[i] = crc_upd(crc[i], b[i]);
            sample(b[7:4]);
            exp_q.push_back(b);
            sample(b[3:0]);
            if (mid_start && j == 0) start_pulse();
        end
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 4; i++) nb[i] = crc[i][15-k];
            if (flip2 && k == 0) nb[2] = ~nb[2];
            sample(nb);
        end
        sample(endn);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_done;
        int rx_base;
        exp_done = 0;

        repeat (3) @(negedge clk);
        chk("reset_busy", {31'h0, busy}, 32'h0);
        chk("reset_rx_data", {24'h0, rx_data}, 32'h0);
        reset_n = 1'b1;
        settle();
        chk("idle_outputs", {24'h0, rx_data, 3'h0, rx_valid, busy, done, crc_err, end_err, timeout_err} & 32'hFFFF_FF3F,
            32'h0);

        // Nominal block with idle samples before the start bit.
        start_pulse();
        chk("busy_after_start", {31'h0, busy}, 32'h1);
        repeat (3) sample(4'hF);
        chk("still_waiting", {31'h0, busy}, 32'h1);
        send_block(32'h1234ABCD, 1'b0, 4'hF, 1'b0);
        exp_done++;
        chk("t1_done", {31'h0, done}, 32'h1);
        chk("t1_errs", {29'h0, crc_err, end_err, timeout_err}, 32'h0);
        settle();
        chk("t1_busy_after", {30'h0, busy, done}, 32'h0);
        chk("t1_done_cnt", done_cnt, exp_done);
        chk("t1_rx_cnt", rx_cnt, 4);

        // All-zero payload, then the same with a DAT2 CRC bit flipped.
        start_pulse();
        send_block(32'h0, 1'b0, 4'hF, 1'b0);
        exp_done++;
        chk("t2_crc_ok", {30'h0, done, crc_err}, 32'h2);
        start_pulse();
        send_block(32'h0, 1'b1, 4'hF, 1'b0);
        exp_done++;
        chk("t2_crc_bad", {29'h0, done, crc_err, end_err}, 32'h6);
        settle();
        chk("t2_crc_sticky", {31'h0, crc_err}, 32'h1);
        chk("t2_rx_cnt", rx_cnt, 12);

        // Bad end nibble; start clears the previous crc_err.
        start_pulse();
        chk("t3_crc_cleared", {31'h0, crc_err}, 32'h0);
        send_block(32'hDEADBEEF, 1'b0, 4'hE, 1'b0);
        exp_done++;
        chk("t3_end_err", {29'h0, done, crc_err, end_err}, 32'h5);

        // Timeout after exactly 8 non-start ticks.
        start_pulse();
        repeat (7) sample(4'hF);
        chk("t4_before_to", {30'h0, busy, timeout_err}, 32'h2);
        sample(4'hB);
        exp_done++;
        chk("t4_timeout", {29'h0, busy, done, timeout_err}, 32'h3);
        settle();
        chk("t4_idle", {30'h0, busy, done}, 32'h0);
        chk("t4_done_cnt", done_cnt, exp_done);

        // Abort coincident with the low nibble of byte 3.
        rx_base = rx_cnt;
        start_pulse();
        sample(4'h0);
        sample(4'h5); exp_q.push_back(8'h5A); sample(4'hA);
        sample(4'hC); exp_q.push_back(8'hC3); sample(4'h3);
        sample(4'h7);
        @(negedge clk);
        sample_en = 1'b1; abort = 1'b1; dat_in = 4'hE;
        @(negedge clk);
        sample_en = 1'b0; abort = 1'b0; dat_in = 4'hF;
        chk("t5_abort_busy", {30'h0, busy, done}, 32'h0);
        repeat (4) sample(4'h1);
        settle();
        chk("t5_abort_rx", rx_cnt - rx_base, 2);
        chk("t5_abort_done", done_cnt, exp_done);

        // Start together with a zero sample: that sample must not count as the start bit.
        @(negedge clk);
        start = 1'b1; sample_en = 1'b1; dat_in = 4'h0;
        @(negedge clk);
        start = 1'b0; sample_en = 1'b0; dat_in = 4'hF;
        send_block(32'h0F1E2D3C, 1'b0, 4'hF, 1'b0);
        exp_done++;
        chk("t5_restart_ok", {28'h0, done, crc_err, end_err, timeout_err}, 32'h8);

        // Asynchronous reset in the middle of DATA.
        start_pulse();
        sample(4'h0);
        sample(4'h1); exp_q.push_back(8'h12); sample(4'h2);
        sample(4'h3); exp_q.push_back(8'h34); sample(4'h4);
        sample(4'h5);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_reset_busy", {31'h0, busy}, 32'h0);
        chk("t6_reset_rx_data", {24'h0, rx_data}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Start while busy is ignored; block still completes cleanly.
        rx_base = rx_cnt;
        start_pulse();
        send_block(32'h9E8D7C6B, 1'b0, 4'hF, 1'b1);
        exp_done++;
        chk("t6_block_ok", {28'h0, done, crc_err, end_err, timeout_err}, 32'h8);
        settle();
        chk("t6_rx_cnt", rx_cnt - rx_base, 4);
        chk("t6_done_cnt", done_cnt, exp_done);
        chk("sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
